// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx line, oversampled start/data/stop deserialiser.
// Emits a one-clk rx_done strobe per frame with the word and a stop-bit framing flag.
module uart_rx #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned SB_TICK    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned SW = $clog2(SB_TICK);
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic            rx_meta_q, rx_s_q;
    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            stop_bit_q, stop_bit_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_done_q, rx_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shift_d     = shift_q;
        stop_bit_d  = stop_bit_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        rx_done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Start edge is taken without waiting for a tick.
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_HALF) begin
                        s_d = '0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        shift_d = {rx_s_q, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        stop_bit_d = rx_s_q;
                    end
                    if (s_q == S_LAST) begin
                        state_d   = IDLE;
                        s_d       = '0;
                        dout_d    = shift_q;
                        rx_done_d = 1'b1;
                        // With a single stop period the mid-bit sample is this very tick.
                        frame_err_d = (s_q == S_MID) ? ~rx_s_q : ~stop_bit_q;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            stop_bit_q  <= 1'b0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            stop_bit_q  <= stop_bit_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            rx_done_q   <= rx_done_d;
        end
    end

    assign dout      = dout_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver with SB_TICK=16, one with SB_TICK=32.
// Frames are timed in ticks (tick every 4 clk, 16 ticks per bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic       tick_en = 1'b0;
    logic       line = 1'b1;
    logic       use2 = 1'b0;
    logic       rx, rx2;
    logic [7:0] dout, dout2;
    logic       rx_done, rx_done2, frame_err, frame_err2, busy, busy2;

    int n_checks = 0;
    int n_errors = 0;
    int clk_cnt  = 0;
    int tick_num = 0;
    int t0       = 0;

    // Captured at each rx_done pulse.
    int         d1_cnt = 0, d2_cnt = 0, dbl = 0;
    logic [7:0] log_dout [16];
    logic       log_ferr [16];
    int         d1_tick = 0, d2_tick = 0;
    logic [7:0] d2_dout = '0;
    logic       d2_ferr = 1'b0;
    logic       d1_prev = 1'b0, d2_prev = 1'b0;

    assign rx  = use2 ? 1'b1 : line;
    assign rx2 = use2 ? line : 1'b1;

    uart_rx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx),
        .dout(dout), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
    );

    uart_rx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(32)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx2),
        .dout(dout2), .rx_done(rx_done2), .frame_err(frame_err2), .busy(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            clk_cnt++;
            tick = tick_en && (clk_cnt % 4 == 0);
        end
    end

    always @(posedge clk) if (tick) tick_num <= tick_num + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            log_dout[d1_cnt % 16] = dout;
            log_ferr[d1_cnt % 16] = frame_err;
            d1_tick = tick_num;
            d1_cnt++;
        end
        if (rx_done2) begin
            d2_dout = dout2;
            d2_ferr = frame_err2;
            d2_tick = tick_num;
            d2_cnt++;
        end
        if ((rx_done && d1_prev) || (rx_done2 && d2_prev)) dbl++;
        d1_prev = rx_done;
        d2_prev = rx_done2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after the clk edge that consumed the k-th tick.
    task automatic wait_ticks(input int k);
        for (int j = 0; j < k; j++) begin
            int guard = 0;
            @(posedge clk);
            while (!tick && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 200) check("tick_timeout", guard, 0);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_ticks,
                              input int freeze_bit, input int abort_bit);
        t0   = tick_num;
        line = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            line = data[i];
            if (i == freeze_bit) begin
                int cnt_before = d1_cnt;
                wait_ticks(4);
                tick_en = 1'b0;
                repeat (50) @(posedge clk);
                #1;
                check("freeze_busy", busy, 1);
                check("freeze_no_done", d1_cnt, cnt_before);
                tick_en = 1'b1;
                wait_ticks(12);
            end else if (i == abort_bit) begin
                wait_ticks(8);
                reset = 1'b1;
                line  = 1'b1;
                return;
            end else begin
                wait_ticks(16);
            end
        end
        line = stop_val;
        wait_ticks(stop_ticks);
        line = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_rx_done", rx_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_dout2", dout2, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        tick_en = 1'b1;
        wait_ticks(10);

        // Good frame; completion lands 152 ticks after the start edge.
        send_frame(8'h55, 1'b1, 16, -1, -1);
        wait_ticks(2);
        check("f55_count", d1_cnt, 1);
        check("f55_dout", log_dout[0], 8'h55);
        check("f55_ferr", log_ferr[0], 0);
        check("f55_latency", d1_tick - t0, 152);
        check("f55_busy", busy, 0);

        // Stop bit low for 12 ticks, covering the mid-stop sample only.
        send_frame(8'hA3, 1'b0, 12, -1, -1);
        wait_ticks(20);
        check("fa3_count", d1_cnt, 2);
        check("fa3_dout", log_dout[1], 8'hA3);
        check("fa3_ferr", log_ferr[1], 1);
        check("fa3_busy", busy, 0);

        // Glitch: low for 4 ticks only.
        line = 1'b0;
        wait_ticks(2);
        check("glitch_busy_hi", busy, 1);
        wait_ticks(2);
        line = 1'b1;
        wait_ticks(6);
        check("glitch_busy_lo", busy, 0);
        check("glitch_no_done", d1_cnt, 2);
        check("glitch_dout", dout, 8'hA3);
        check("glitch_ferr", frame_err, 1);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 16, -1, -1);
        send_frame(8'hFF, 1'b1, 16, -1, -1);
        wait_ticks(10);
        check("b2b_count", d1_cnt, 4);
        check("b2b_dout0", log_dout[2], 8'h00);
        check("b2b_ferr0", log_ferr[2], 0);
        check("b2b_dout1", log_dout[3], 8'hFF);
        check("b2b_ferr1", log_ferr[3], 0);

        // Reset mid data bit 4 of 0x3C.
        send_frame(8'h3C, 1'b1, 16, -1, 4);
        repeat (2) @(negedge clk);
        check("abort_dout", dout, 8'h00);
        check("abort_rx_done", rx_done, 0);
        check("abort_ferr", frame_err, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ticks(20);
        check("abort_no_done", d1_cnt, 4);
        send_frame(8'hC3, 1'b1, 16, -1, -1);
        wait_ticks(4);
        check("c3_count", d1_cnt, 5);
        check("c3_dout", log_dout[4], 8'hC3);
        check("c3_ferr", log_ferr[4], 0);
        check("c3_dout_held", dout, 8'hC3);

        // Tick stalled 50 clk in the middle of bit 5.
        send_frame(8'h96, 1'b1, 16, 5, -1);
        wait_ticks(4);
        check("f96_count", d1_cnt, 6);
        check("f96_dout", log_dout[5], 8'h96);
        check("f96_ferr", log_ferr[5], 0);

        // Two stop bits on the SB_TICK=32 receiver: done 32 ticks after the bit-7 sample.
        use2 = 1'b1;
        wait_ticks(4);
        send_frame(8'h81, 1'b1, 32, -1, -1);
        wait_ticks(4);
        use2 = 1'b0;
        check("sb32_count", d2_cnt, 1);
        check("sb32_dout", d2_dout, 8'h81);
        check("sb32_ferr", d2_ferr, 0);
        check("sb32_latency", d2_tick - t0, 168);
        check("sb32_busy", busy2, 0);
        check("sb32_dut1_quiet", d1_cnt, 6);

        check("no_double_pulse", dbl, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
